serial_frame_rx: RTL and testbench

//  Consumes the 1-bit stream from the shift-register stage and rebuilds parallel words.

---
 rtl/serial_frame_rx.sv | 129 ++++++++++++
 tb/tb_serial_frame_rx.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/serial_frame_rx.sv
// Serial frame receiver: start bit, DATA_W data bits, optional even parity, stop bit.
// Good words are held in a 1-deep valid/ready buffer; parity, framing and overrun errors are flagged.
module serial_frame_rx #(
  parameter int DATA_W    = 8,
  parameter bit LSB_FIRST = 1'b1,
  parameter bit PARITY_EN = 1'b1
) (
  input  logic              i_clk,
  input  logic              i_rstn,
  input  logic              i_serial,
  input  logic              i_bit_en,
  input  logic              i_ready,
  input  logic              i_clr_err,
  output logic [DATA_W-1:0] o_data,
  output logic              o_valid,
  output logic              o_parity_err,
  output logic              o_frame_err,
  output logic              o_overrun,
  output logic              o_busy
);

  localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [DATA_W-1:0]   shift_q, shift_d;
  logic                par_q, par_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic                valid_q, valid_d;
  logic                perr_q, perr_d;
  logic                ferr_q, ferr_d;
  logic                ovr_q, ovr_d;
  logic                last_bit;
  logic                commit;
  logic                perr_new;

  assign last_bit = (cnt_q == CNT_W'(DATA_W - 1));
  assign perr_new = PARITY_EN ? ((^shift_q) ^ par_q) : 1'b0;

  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
      data_q  <= '0;
      valid_q <= 1'b0;
      perr_q  <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      perr_q  <= perr_d;
      ferr_q  <= ferr_d;
      ovr_q   <= ovr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (i_bit_en) begin
      case (state_q)
        IDLE:    if (!i_serial) state_d = DATA;
        DATA:    if (last_bit) state_d = PARITY_EN ? PARITY : STOP;
        PARITY:  state_d = STOP;
        STOP:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // Shift path, stop-bit check and output buffer update.
  always_comb begin
    cnt_d   = cnt_q;
    shift_d = shift_q;
    par_d   = par_q;
    ferr_d  = 1'b0;
    commit  = 1'b0;
    if (i_bit_en) begin
      case (state_q)
        IDLE: cnt_d = '0;
        DATA: begin
          cnt_d = cnt_q + 1'b1;
          if (LSB_FIRST)
            shift_d = (shift_q >> 1) | (DATA_W'(i_serial) << (DATA_W - 1));
          else
            shift_d = (shift_q << 1) | DATA_W'(i_serial);
        end
        PARITY: par_d = i_serial;
        STOP: begin
          if (i_serial) commit = 1'b1;
          else          ferr_d = 1'b1;
        end
        default: ;
      endcase
    end

    valid_d = valid_q;
    data_d  = data_q;
    perr_d  = perr_q;
    ovr_d   = ovr_q & ~i_clr_err;
    if (commit && (!valid_q || i_ready)) begin
      valid_d = 1'b1;
      data_d  = shift_q;
      perr_d  = perr_new;
    end else if (commit) begin
      ovr_d = 1'b1;
    end else if (valid_q && i_ready) begin
      valid_d = 1'b0;
    end
  end

  always_comb begin
    o_data       = data_q;
    o_valid      = valid_q;
    o_parity_err = perr_q;
    o_frame_err  = ferr_q;
    o_overrun    = ovr_q;
    o_busy       = (state_q != IDLE);
  end

endmodule

// File: tb/tb_serial_frame_rx.sv
// Bench for serial_frame_rx: frame table plus hand sequences for overrun, consume-on-commit and reset.
module tb_serial_frame_rx;

  logic       i_clk = 1'b0;
  logic       i_rstn, i_serial, i_bit_en, i_ready, i_clr_err;
  logic [7:0] o_data;
  logic       o_valid, o_parity_err, o_frame_err, o_overrun, o_busy;

  serial_frame_rx #(.DATA_W(8), .LSB_FIRST(1'b1), .PARITY_EN(1'b1)) dut (
    .i_clk(i_clk), .i_rstn(i_rstn), .i_serial(i_serial), .i_bit_en(i_bit_en),
    .i_ready(i_ready), .i_clr_err(i_clr_err), .o_data(o_data), .o_valid(o_valid),
    .o_parity_err(o_parity_err), .o_frame_err(o_frame_err), .o_overrun(o_overrun),
    .o_busy(o_busy)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic [7:0] data;
    logic       par;
    logic       stop;
    logic       exp_perr;
    logic       exp_ferr;
  } vec_t;

  typedef struct {
    logic [7:0] d;
    logic       pe;
  } exp_t;

  vec_t vecs[7];
  exp_t sbq[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   ferr_seen = 0;
  logic clr_on_stop = 1'b0;
  logic ready_on_stop = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Sample at the falling edge (scoreboard pop on handshake), then step past the next rising edge.
  task automatic tick();
    exp_t e;
    @(negedge i_clk);
    if (o_frame_err) ferr_seen++;
    if (o_valid && i_ready) begin
      if (sbq.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL sb_unexpected: got word %0h expected none", o_data);
      end else begin
        e = sbq.pop_front();
        chk("sb_data", {23'd0, o_parity_err, o_data}, {23'd0, e.pe, e.d});
      end
    end
    @(posedge i_clk);
    #1;
  endtask

  task automatic send_bit(input logic b, input int gap);
    i_serial = b;
    i_bit_en = 1'b1;
    tick();
    i_bit_en = 1'b0;
    repeat (gap) tick();
  endtask

  task automatic send_frame(input logic [7:0] d, input logic p, input logic s, input int gap);
    send_bit(1'b0, gap);
    for (int i = 0; i < 8; i++) send_bit(d[i], gap);
    send_bit(p, gap);
    if (clr_on_stop) i_clr_err = 1'b1;
    if (ready_on_stop) i_ready = 1'b1;
    i_serial = s;
    i_bit_en = 1'b1;
    tick();
    i_bit_en  = 1'b0;
    i_clr_err = 1'b0;
    i_serial  = 1'b1;
    repeat (gap) tick();
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_data"},  {24'd0, o_data}, 32'd0);
    chk({tag, "_valid"}, {31'd0, o_valid}, 32'd0);
    chk({tag, "_perr"},  {31'd0, o_parity_err}, 32'd0);
    chk({tag, "_ferr"},  {31'd0, o_frame_err}, 32'd0);
    chk({tag, "_ovr"},   {31'd0, o_overrun}, 32'd0);
    chk({tag, "_busy"},  {31'd0, o_busy}, 32'd0);
  endtask

  initial begin
    int f0;
    vecs[0] = '{8'hA5, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[1] = '{8'h3C, 1'b1, 1'b1, 1'b1, 1'b0};
    vecs[2] = '{8'h81, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[3] = '{8'hFF, 1'b1, 1'b1, 1'b1, 1'b0};
    vecs[4] = '{8'h00, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[5] = '{8'h6B, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[6] = '{8'h13, 1'b0, 1'b1, 1'b1, 1'b0};

    i_rstn = 1'b0; i_serial = 1'b1; i_bit_en = 1'b0; i_ready = 1'b1; i_clr_err = 1'b0;
    tick(); tick();
    chk_all_zero("reset");
    i_rstn = 1'b1;
    tick();

    // A5: o_valid high for exactly one cycle with ready held
    sbq.push_back('{8'hA5, 1'b0});
    send_frame(8'hA5, 1'b0, 1'b1, 0);
    chk("t1_valid_hi", {31'd0, o_valid}, 32'd1);
    chk("t1_data", {24'd0, o_data}, 32'hA5);
    tick();
    chk("t1_valid_lo", {31'd0, o_valid}, 32'd0);
    repeat (2) tick();

    // Table frames, first with a strobe every cycle, then every 4th cycle
    for (int g = 0; g <= 3; g += 3) begin
      for (int k = 0; k < 7; k++) begin
        f0 = ferr_seen;
        if (!vecs[k].exp_ferr) sbq.push_back('{vecs[k].data, vecs[k].exp_perr});
        send_frame(vecs[k].data, vecs[k].par, vecs[k].stop, g);
        repeat (2) tick();
        chk("tbl_ferr_pulses", ferr_seen - f0, {31'd0, vecs[k].exp_ferr});
        chk("tbl_busy", {31'd0, o_busy}, 32'd0);
        chk("tbl_valid_idle", {31'd0, o_valid}, 32'd0);
      end
    end
    chk("tbl_sb_empty", sbq.size(), 32'd0);

    // Back-to-back frames: next start bit on the strobe after the stop bit
    sbq.push_back('{8'h5A, 1'b0});
    sbq.push_back('{8'hC3, 1'b0});
    send_frame(8'h5A, 1'b0, 1'b1, 0);
    send_frame(8'hC3, 1'b0, 1'b1, 0);
    repeat (2) tick();
    chk("b2b_sb_empty", sbq.size(), 32'd0);

    // Overrun: buffer full with ready low
    i_ready = 1'b0;
    sbq.push_back('{8'h11, 1'b0});
    send_frame(8'h11, 1'b0, 1'b1, 0);
    send_frame(8'h22, 1'b0, 1'b1, 0);
    tick();
    chk("ovr_data", {24'd0, o_data}, 32'h11);
    chk("ovr_valid", {31'd0, o_valid}, 32'd1);
    chk("ovr_set", {31'd0, o_overrun}, 32'd1);
    i_clr_err = 1'b1; tick(); i_clr_err = 1'b0;
    chk("ovr_clr", {31'd0, o_overrun}, 32'd0);
    clr_on_stop = 1'b1;
    send_frame(8'h33, 1'b0, 1'b1, 0);
    clr_on_stop = 1'b0;
    chk("ovr_set_wins", {31'd0, o_overrun}, 32'd1);
    chk("ovr_data_kept", {24'd0, o_data}, 32'h11);
    i_clr_err = 1'b1; tick(); i_clr_err = 1'b0;
    i_ready = 1'b1;
    repeat (2) tick();
    chk("ovr_consumed", {31'd0, o_valid}, 32'd0);
    chk("ovr_sb_empty", sbq.size(), 32'd0);
    chk("ovr_after_clr", {31'd0, o_overrun}, 32'd0);

    // Consume and commit on the same edge
    i_ready = 1'b0;
    sbq.push_back('{8'h55, 1'b0});
    send_frame(8'h55, 1'b0, 1'b1, 0);
    tick();
    sbq.push_back('{8'h66, 1'b0});
    ready_on_stop = 1'b1;
    send_frame(8'h66, 1'b0, 1'b1, 0);
    ready_on_stop = 1'b0;
    chk("cc_valid", {31'd0, o_valid}, 32'd1);
    chk("cc_data", {24'd0, o_data}, 32'h66);
    chk("cc_ovr", {31'd0, o_overrun}, 32'd0);
    repeat (2) tick();
    chk("cc_sb_empty", sbq.size(), 32'd0);

    // Reset mid-frame with a buffered word pending
    i_ready = 1'b0;
    send_frame(8'h77, 1'b0, 1'b1, 0);
    send_bit(1'b0, 0);
    for (int i = 0; i < 4; i++) send_bit(1'b0, 0);
    chk("rst_busy_before", {31'd0, o_busy}, 32'd1);
    i_rstn = 1'b0; tick(); i_rstn = 1'b1;
    chk_all_zero("midrst");
    i_ready = 1'b1;
    sbq.push_back('{8'h0F, 1'b0});
    send_frame(8'h0F, 1'b0, 1'b1, 0);
    repeat (2) tick();
    chk("rst_sb_empty", sbq.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
